// File: rtl/pp_accum_seq.sv
// Multi-lane shifted partial-product accumulator with a valid/ready input and
// a held result. The result register doubles as the accumulator.
module pp_accum_seq #(
    parameter int PP_W    = 43,
    parameter int RADIX   = 78,
    parameter int LANES   = 5,
    parameter int SHIFT_W = 8,
    localparam int ACC_W  = 2 * RADIX
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*PP_W-1:0]    in_pp,
    input  logic [LANES*SHIFT_W-1:0] in_shift,
    input  logic [LANES-1:0]         in_mask,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic                     out_ovf,
    output logic [7:0]               out_beats
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic               ovf, ovf_n;
    logic [7:0]         beats, beats_n;

    logic               accept;
    logic               fire;
    logic               start_new;
    logic [SHIFT_W-1:0] lane_sh;
    logic [PP_W-1:0]    lane_pp;
    logic [ACC_W+PP_W-1:0] lane_wide;
    logic [ACC_W+2:0]   sum;
    logic               lane_drop;

    assign out_valid = (state == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    // A beat arriving in IDLE or HOLD opens a fresh result.
    assign start_new = (state != ACCUM);

    assign out_data  = acc;
    assign out_ovf   = ovf;
    assign out_beats = beats;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        lane_sh   = '0;
        lane_pp   = '0;
        lane_wide = '0;
        lane_drop = 1'b0;
        sum       = start_new ? '0 : {3'b000, acc};
        for (int i = 0; i < LANES; i++) begin
            lane_sh = in_shift[i*SHIFT_W +: SHIFT_W];
            lane_pp = in_pp[i*PP_W +: PP_W];
            if (in_mask[i]) begin
                if (int'(lane_sh) >= ACC_W) begin
                    lane_drop = lane_drop | (|lane_pp);
                end else begin
                    // Shift below ACC_W keeps the whole product inside ACC_W+PP_W bits.
                    lane_wide = {{ACC_W{1'b0}}, lane_pp} << lane_sh;
                    lane_drop = lane_drop | (|lane_wide[ACC_W+PP_W-1:ACC_W]);
                    sum       = sum + {3'b000, lane_wide[ACC_W-1:0]};
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        ovf_n   = ovf;
        beats_n = beats;
        if (accept) begin
            acc_n   = sum[ACC_W-1:0];
            ovf_n   = (start_new ? 1'b0 : ovf) | lane_drop | (|sum[ACC_W+2:ACC_W]);
            beats_n = start_new ? 8'd1 : ((beats == 8'hFF) ? 8'hFF : beats + 8'd1);
            state_n = in_last ? HOLD : ACCUM;
        end else if (fire) begin
            state_n = IDLE;
            acc_n   = '0;
            ovf_n   = 1'b0;
            beats_n = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            beats <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ovf   <= ovf_n;
            beats <= beats_n;
        end
    end

endmodule
